// File: rtl/ex_muldiv_if.sv
// Issue/result handshake between the EX stage and the iterative multiply-divide unit.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            flush_in;
  logic            valid_in;
  logic            ready_out;
  logic [2:0]      op_in;
  logic [XLEN-1:0] rs1_val_in;
  logic [XLEN-1:0] rs2_val_in;
  logic [4:0]      rd_addr_in;
  logic            valid_out;
  logic            ready_in;
  logic [XLEN-1:0] rd_val_out;
  logic [4:0]      rd_addr_out;
  logic            stallreq_out;

  modport slave (
    input  flush_in, valid_in, op_in, rs1_val_in, rs2_val_in, rd_addr_in, ready_in,
    output ready_out, valid_out, rd_val_out, rd_addr_out, stallreq_out
  );

  modport master (
    output flush_in, valid_in, op_in, rs1_val_in, rs2_val_in, rd_addr_in, ready_in,
    input  ready_out, valid_out, rd_val_out, rd_addr_out, stallreq_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiply, restoring divide,
// magnitude datapath with a single sign-fixup cycle before handing off to MEM.
module ex_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input logic        clk_in,
  input logic        rstn_in,
  ex_muldiv_if.slave bus
);
  localparam int              K_MUL   = XLEN / MUL_STEP;
  localparam int              CW      = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   K_MUL_C = CW'(K_MUL);
  localparam logic [CW-1:0]   K_DIV_C = CW'(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   ma, mb;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_q, sa_q, spec_q;
  logic              valid_r, ready_r;
  logic [XLEN-1:0]   rd_val_r;
  logic [4:0]        rd_addr_r;

  logic [XLEN-1:0] a, b, abs_a, abs_b, spec_val;
  logic            a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, special;

  assign a = bus.rs1_val_in;
  assign b = bus.rs2_val_in;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.op_in)
      3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'd2:             a_sgn = 1'b1;
      default:          ;
    endcase
  end

  assign a_neg  = a_sgn & a[XLEN-1];
  assign b_neg  = b_sgn & b[XLEN-1];
  assign abs_a  = a_neg ? -a : a;
  assign abs_b  = b_neg ? -b : b;
  assign b_zero = (b == '0);
  assign ovf    = a_sgn & b_sgn & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
  assign special = bus.op_in[2] & (b_zero | ovf);
  // op[1] selects remainder: div-by-zero gives A / all ones, overflow gives 0 / A
  assign spec_val = b_zero ? (bus.op_in[1] ? a : '1) : (bus.op_in[1] ? '0 : a);

  // Shift-add: multiplier sits in acc low half and drains out MUL_STEP bits per step
  logic [XLEN+MUL_STEP-1:0] mul_pp, mul_hi;
  logic [2*XLEN-1:0]        mul_nxt;
  assign mul_pp  = {{MUL_STEP{1'b0}}, ma} * {{XLEN{1'b0}}, acc[MUL_STEP-1:0]};
  assign mul_hi  = {{MUL_STEP{1'b0}}, acc[2*XLEN-1:XLEN]} + mul_pp;
  assign mul_nxt = {mul_hi, acc[XLEN-1:MUL_STEP]};

  // Restoring divide: acc = {remainder, dividend/quotient}; borrow bit decides restore
  logic [XLEN:0]     sh, dif;
  logic [2*XLEN-1:0] div_nxt;
  assign sh      = acc[2*XLEN-1:XLEN-1];
  assign dif     = sh - {1'b0, mb};
  assign div_nxt = dif[XLEN] ? {sh[XLEN-1:0],  acc[XLEN-2:0], 1'b0}
                             : {dif[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;
  logic [CW-1:0]     k_end;
  assign prod  = neg_q ? -acc : acc;
  assign quo   = acc[XLEN-1:0];
  assign rem   = acc[2*XLEN-1:XLEN];
  assign k_end = op_q[2] ? K_DIV_C : K_MUL_C;

  always_comb begin
    fix_res = '0;
    if (!op_q[2])    fix_res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1]) fix_res = sa_q ? -rem : rem;
    else              fix_res = neg_q ? -quo : quo;
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      ma        <= '0;
      mb        <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      sa_q      <= 1'b0;
      spec_q    <= 1'b0;
      valid_r   <= 1'b0;
      ready_r   <= 1'b1;
      rd_val_r  <= '0;
      rd_addr_r <= '0;
    end else if (bus.flush_in) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.valid_in && ready_r) begin
          state   <= CALC;
          ready_r <= 1'b0;
          cnt     <= '0;
          op_q    <= bus.op_in;
          rd_q    <= bus.rd_addr_in;
          neg_q   <= a_neg ^ b_neg;
          sa_q    <= a_neg;
          spec_q  <= special;
          ma      <= abs_a;
          mb      <= abs_b;
          if (special)           acc <= {{XLEN{1'b0}}, spec_val};
          else if (bus.op_in[2]) acc <= {{XLEN{1'b0}}, abs_a};
          else                   acc <= {{XLEN{1'b0}}, abs_b};
        end
        // One edge past the final step is spent leaving CALC
        CALC: if (spec_q) begin
          state     <= DONE;
          rd_val_r  <= acc[XLEN-1:0];
          rd_addr_r <= rd_q;
          valid_r   <= 1'b1;
        end else if (cnt == k_end) begin
          state <= FIX;
          cnt   <= '0;
        end else begin
          acc <= op_q[2] ? div_nxt : mul_nxt;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          state     <= DONE;
          rd_val_r  <= fix_res;
          rd_addr_r <= rd_q;
          valid_r   <= 1'b1;
        end
        DONE: if (bus.ready_in) begin
          state   <= IDLE;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.valid_out    = valid_r;
  assign bus.ready_out    = ready_r;
  assign bus.rd_val_out   = rd_val_r;
  assign bus.rd_addr_out  = rd_addr_r;
  assign bus.stallreq_out = (state != IDLE) | (bus.valid_in & ~ready_r);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed vector table plus hand sequences for flush, back-pressure and mid-op reset.
module tb_ex_muldiv_unit;
  localparam int XLEN = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(XLEN)) bus();
  ex_muldiv_unit #(.XLEN(XLEN), .MUL_STEP(1)) dut (
    .clk_in (clk),
    .rstn_in(rstn),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [2:0] op, input logic [31:0] a, b, exp, input int lat, hold);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.hold = hold;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input logic [4:0] rd);
    @(negedge clk);
    bus.valid_in   = 1'b1;
    bus.op_in      = op;
    bus.rs1_val_in = a;
    bus.rs2_val_in = b;
    bus.rd_addr_in = rd;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int lat);
    lat = 0;
    while (!bus.valid_out && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.valid_out) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: valid_out never rose within %0d cycles", nm, lat);
    end
  endtask

  task automatic handoff(input string nm);
    @(negedge clk);
    bus.ready_in = 1'b1;
    @(posedge clk); #1;
    bus.ready_in = 1'b0;
    chk({nm, " valid after xfer"}, 32'(bus.valid_out), 32'd0);
    chk({nm, " ready after xfer"}, 32'(bus.ready_out), 32'd1);
    chk({nm, " stall after xfer"}, 32'(bus.stallreq_out), 32'd0);
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, b, exp,
                        input logic [4:0] rd, input int exp_lat, input int hold);
    int lat;
    issue(op, a, b, rd);
    chk({nm, " stall busy"}, 32'(bus.stallreq_out), 32'd1);
    chk({nm, " ready busy"}, 32'(bus.ready_out), 32'd0);
    wait_valid(nm, lat);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " rd_val"}, bus.rd_val_out, exp);
    chk({nm, " rd_addr"}, 32'(bus.rd_addr_out), 32'(rd));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, " hold valid"}, 32'(bus.valid_out), 32'd1);
      chk({nm, " hold rd_val"}, bus.rd_val_out, exp);
      chk({nm, " hold rd_addr"}, 32'(bus.rd_addr_out), 32'(rd));
    end
    handoff(nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    bus.flush_in = 1'b0; bus.valid_in = 1'b0; bus.op_in = '0; bus.ready_in = 1'b0;
    bus.rs1_val_in = '0; bus.rs2_val_in = '0; bus.rd_addr_in = '0;

    //    op     A             B             expected      lat hold
    add(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 5);
    add(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
    add(3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
    add(3'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 34, 0);
    add(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0);
    add(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0);
    add(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    add(3'd7, 32'd5,        32'd0,        32'd5,        1,  0);
    add(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  2);
    add(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0);
    add(3'd0, 32'd3,        32'd4,        32'd12,       34, 0);
    add(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        34, 0);
    add(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
    add(3'd5, 32'd100,      32'd7,        32'd14,       34, 0);
    add(3'd7, 32'd100,      32'd7,        32'd2,        34, 0);
    add(3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 0);
    add(3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        34, 0);
    add(3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1,  0);
    add(3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  0);
    add(3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 0);
    add(3'd4, 32'h80000000, 32'd1,        32'h80000000, 34, 0);
    add(3'd6, 32'h80000000, 32'd3,        32'hFFFFFFFE, 34, 0);
    add(3'd0, 32'h12345678, 32'h10,       32'h23456780, 34, 0);
    add(3'd3, 32'h12345678, 32'h10,       32'd1,        34, 0);

    #2 rstn = 1'b0;
    #2;
    chk("reset valid_out", 32'(bus.valid_out), 32'd0);
    chk("reset ready_out", 32'(bus.ready_out), 32'd1);
    chk("reset stallreq", 32'(bus.stallreq_out), 32'd0);
    chk("reset rd_val", bus.rd_val_out, 32'd0);
    chk("reset rd_addr", 32'(bus.rd_addr_out), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             5'(i + 1), vecs[i].lat, vecs[i].hold);

    // Flush mid-CALC: no result, old outputs retained, then a clean op
    issue(3'd0, 32'd5, 32'd6, 5'd20);
    repeat (10) @(posedge clk);
    @(negedge clk) bus.flush_in = 1'b1;
    @(posedge clk); #1;
    bus.flush_in = 1'b0;
    chk("flush ready", 32'(bus.ready_out), 32'd1);
    chk("flush valid", 32'(bus.valid_out), 32'd0);
    chk("flush stall", 32'(bus.stallreq_out), 32'd0);
    chk("flush rd_val held", bus.rd_val_out, 32'd1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= bus.valid_out; end
    chk("flush no valid", 32'(seen), 32'd0);
    run_op("post-flush mul", 3'd0, 32'd3, 32'd4, 32'd12, 5'd21, 34, 0);

    // valid_in while busy is stalled and ignored
    issue(3'd0, 32'd9, 32'd9, 5'd22);
    @(negedge clk);
    bus.valid_in = 1'b1; bus.op_in = 3'd5; bus.rs1_val_in = 32'd1; bus.rs2_val_in = 32'd0;
    bus.rd_addr_in = 5'd3;
    #1;
    chk("busy stallreq", 32'(bus.stallreq_out), 32'd1);
    chk("busy ready", 32'(bus.ready_out), 32'd0);
    repeat (3) @(posedge clk);
    #1 bus.valid_in = 1'b0;
    wait_valid("busy op", lat);
    chk("busy op rd_val", bus.rd_val_out, 32'd81);
    chk("busy op rd_addr", 32'(bus.rd_addr_out), 32'd22);
    handoff("busy op");

    // Flush wins over DONE transfer
    issue(3'd5, 32'd5, 32'd0, 5'd23);
    wait_valid("flush-done", lat);
    @(negedge clk);
    bus.ready_in = 1'b1; bus.flush_in = 1'b1;
    @(posedge clk); #1;
    bus.ready_in = 1'b0; bus.flush_in = 1'b0;
    chk("flush-done valid", 32'(bus.valid_out), 32'd0);
    chk("flush-done ready", 32'(bus.ready_out), 32'd1);

    // Flush wins over accept
    @(negedge clk);
    bus.valid_in = 1'b1; bus.flush_in = 1'b1; bus.op_in = 3'd7;
    bus.rs1_val_in = 32'd9; bus.rs2_val_in = 32'd0;
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.flush_in = 1'b0;
    chk("flush-accept ready", 32'(bus.ready_out), 32'd1);
    chk("flush-accept stall", 32'(bus.stallreq_out), 32'd0);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= bus.valid_out; end
    chk("flush-accept no valid", 32'(seen), 32'd0);

    // Asynchronous reset mid-CALC
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd9);
    repeat (5) @(posedge clk);
    @(negedge clk) rstn = 1'b0;
    #1;
    chk("midreset valid", 32'(bus.valid_out), 32'd0);
    chk("midreset ready", 32'(bus.ready_out), 32'd1);
    chk("midreset stall", 32'(bus.stallreq_out), 32'd0);
    chk("midreset rd_val", bus.rd_val_out, 32'd0);
    chk("midreset rd_addr", 32'(bus.rd_addr_out), 32'd0);
    @(negedge clk) rstn = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= bus.valid_out; end
    chk("midreset no valid", 32'(seen), 32'd0);
    run_op("post-reset div", 3'd4, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 5'd30, 34, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
